// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, sync-ROM read port and 2-entry fetch buffer feeding decode.
// Latency: a word read in cycle k is valid to decode in cycle k+2; sustains 1 word/cycle.
// Backpressure: id_ready low holds the head word; reads stop once both buffer slots are claimed.
// Ports: clk, rst_n (sync, active-low); imem_addr/imem_rd/imem_data ROM port (data one cycle after rd);
//   if_valid/id_ready handshake carrying class_out, ISout, pc_out; branch_en/branch_target redirect;
//   halted flags that a HALT word stopped fetching.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [15:0]       imem_data,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [1:0]        class_out,
  output logic [13:0]       ISout,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted
);

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       word;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              live_q;            // low for the first cycle after reset
  logic              infl_q, infl_d;    // ROM data for infl_pc arrives this cycle
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  entry_t            slot0_q, slot0_d;  // slot0 is always the head
  entry_t            slot1_q, slot1_d;
  logic [1:0]        cnt_q, cnt_d;

  logic       pop, push, room;
  logic [1:0] fill;
  logic [2:0] claimed;
  entry_t     new_e;

  assign if_valid  = (cnt_q != 2'd0);
  assign imem_addr = pc_q;
  assign halted    = (state_q == HALTED);
  assign class_out = if_valid ? slot0_q.word[15:14] : 2'b00;
  assign ISout     = if_valid ? slot0_q.word[13:0]  : 14'h0;
  assign pc_out    = if_valid ? slot0_q.pc          : '0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_d    = 1'b0;
    infl_pc_d = infl_pc_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    cnt_d     = cnt_q;

    pop   = if_valid & id_ready;
    push  = infl_q;
    new_e = '{pc: infl_pc_q, word: imem_data};
    fill  = cnt_q - {1'b0, pop};

    // Slots already spoken for once this cycle's pop leaves; a new read is only
    // issued if its word is guaranteed a slot even if decode stalls next cycle.
    claimed = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    room    = (claimed < 3'd2);

    // A branch wins over everything, so its cycle issues nothing from the old stream.
    imem_rd = live_q && (state_q == RUN) && !branch_en && room;

    if (branch_en) begin
      cnt_d   = 2'd0;
      pc_d    = branch_target;
      state_d = RUN;
      infl_d  = 1'b0;
    end else begin
      if (imem_rd) begin
        pc_d      = pc_q + ADDR_W'(1);
        infl_d    = 1'b1;
        infl_pc_d = pc_q;
      end
      if (pop) begin
        slot0_d = slot1_q;
      end
      if (push) begin
        if (fill == 2'd0) slot0_d = new_e;
        else              slot1_d = new_e;
        // HALT: class 00 with [13:9] all ones. The read issued alongside it is
        // for a word past the HALT, so it is dropped.
        if (new_e.word[15:9] == 7'b0011111) begin
          state_d = HALTED;
          infl_d  = 1'b0;
        end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      live_q    <= 1'b0;
      infl_q    <= 1'b0;
      infl_pc_q <= RESET_PC;
      slot0_q   <= '0;
      slot1_q   <= '0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      live_q    <= 1'b1;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      cnt_q     <= cnt_d;
    end
  end

  // The issue credit must never let a returning word land on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !branch_en && cnt_q == 2'd2));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        id_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  imem_addr, imem_addr_w;
  logic        imem_rd, imem_rd_w;
  logic [15:0] imem_data = 16'h0, imem_data_w = 16'h0;
  logic        if_valid, if_valid_w;
  logic [1:0]  class_out, class_out_w;
  logic [13:0] ISout, ISout_w;
  logic [7:0]  pc_out, pc_out_w;
  logic        halted, halted_w;

  logic [15:0] rom [0:255];
  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .if_valid(if_valid), .id_ready(id_ready), .class_out(class_out), .ISout(ISout),
    .pc_out(pc_out), .branch_en(branch_en), .branch_target(branch_target), .halted(halted));

  // Second instance only exercises PC wrap-around from a high reset address.
  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFE)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_w), .imem_rd(imem_rd_w), .imem_data(imem_data_w),
    .if_valid(if_valid_w), .id_ready(1'b1), .class_out(class_out_w), .ISout(ISout_w),
    .pc_out(pc_out_w), .branch_en(1'b0), .branch_target(8'h00), .halted(halted_w));

  // Synchronous ROMs: data appears the cycle after the read strobe.
  always @(posedge clk) if (imem_rd)   imem_data   <= rom[imem_addr];
  always @(posedge clk) if (imem_rd_w) imem_data_w <= rom[imem_addr_w];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return at mid-cycle to sample.
  task automatic cyc(input logic rdy, input logic br, input logic [7:0] tgt, input logic rn);
    @(posedge clk);
    #1;
    id_ready = rdy; branch_en = br; branch_target = tgt; rst_n = rn;
    @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:9] == 7'b0011111) w[15] = 1'b1;
    return w;
  endfunction

  function automatic bit is_halt(input logic [15:0] w);
    return (w[15:9] == 7'b0011111);
  endfunction

  // Reference model: delivered stream is rom[pc], rom[pc+1], ... from the last
  // reset or branch target, ending after a HALT word; plus handshake rules.
  logic [7:0]  exp_pc = 8'h00;
  logic [7:0]  br_tgt = 8'h00;
  logic [7:0]  prev_pc = 8'h00;
  logic [15:0] prev_word = 16'h0;
  bit          halt_seen = 1'b0;
  bit          prev_rst_low = 1'b1;
  bit          prev_stall = 1'b0;
  bit          prev_thru = 1'b0;
  int          since_br = 100;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 8'h00; halt_seen = 1'b0; prev_rst_low = 1'b1;
      prev_stall = 1'b0; prev_thru = 1'b0; since_br = 100;
    end else begin
      if (since_br < 100) since_br++;
      if (prev_rst_low) begin
        chk("rst_vld", if_valid, 1'b0);
        chk("rst_pc_out", pc_out, 8'h00);
        chk("rst_word", {class_out, ISout}, 16'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_rd", imem_rd, 1'b0);
        chk("rst_addr", imem_addr, 8'h00);
      end
      if (since_br <= 2) chk("br_bubble", if_valid, 1'b0);
      else if (since_br == 3) begin
        chk("br_vld", if_valid, 1'b1);
        chk("br_pc", pc_out, br_tgt);
      end
      if (prev_stall) begin
        chk("stall_vld", if_valid, 1'b1);
        chk("stall_pc", pc_out, prev_pc);
        chk("stall_word", {class_out, ISout}, prev_word);
      end
      if (prev_thru) chk("thru_vld", if_valid, 1'b1);
      if (halted) chk("halt_no_rd", imem_rd, 1'b0);
      if (halt_seen) chk("halt_hold", halted, 1'b1);

      prev_thru = 1'b0;
      if (if_valid && id_ready && !branch_en) begin
        chk("post_halt_word", halt_seen, 1'b0);
        chk("hs_pc", pc_out, exp_pc);
        chk("hs_word", {class_out, ISout}, rom[exp_pc]);
        if (is_halt({class_out, ISout})) begin
          chk("halt_flag", halted, 1'b1);
          halt_seen = 1'b1;
        end else if (since_br >= 3) begin
          prev_thru = 1'b1;
        end
        exp_pc = exp_pc + 8'd1;
      end
      prev_stall = if_valid && !id_ready && !branch_en;
      prev_pc    = pc_out;
      prev_word  = {class_out, ISout};
      if (branch_en) begin
        exp_pc = branch_target; br_tgt = branch_target;
        halt_seen = 1'b0; since_br = 0; prev_thru = 1'b0;
      end
      prev_rst_low = 1'b0;
    end
  end

  initial begin
    logic [7:0] wpc;
    for (int a = 0; a < 256; a++) rom[a] = rand_word();
    rom[0] = 16'h5201; rom[1] = 16'h4A08; rom[2] = 16'h7C00; rom[3] = 16'h5A12;

    // Straight-line fetch, and wrap from RESET_PC = FE on the second instance.
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("c0_rd", imem_rd, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("c1_rd", imem_rd, 1'b1);
    chk("c1_addr", imem_addr, 8'h00);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    chk("c2_vld", if_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      chk("sl_vld", if_valid, 1'b1);
      chk("sl_pc", pc_out, i);
      chk("sl_word", {class_out, ISout}, rom[i]);
      if (i == 0) begin
        chk("sl_class", class_out, 2'b01);
        chk("sl_is", ISout, 14'h1201);
      end
      wpc = 8'hFE + 8'(i);
      chk("wrap_vld", if_valid_w, 1'b1);
      chk("wrap_pc", pc_out_w, wpc);
    end

    // Stall cycles 4..9, release at 10.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      cyc((c < 4 || c > 9), 1'b0, 8'h00, 1'b1);
      if (c >= 4 && c <= 9) begin
        chk("st_vld", if_valid, 1'b1);
        chk("st_pc", pc_out, 8'h01);
      end
      if (c >= 5 && c <= 9) chk("st_rd", imem_rd, 1'b0);
      if (c >= 10) chk("rel_pc", pc_out, c - 9);
    end

    // Branch with a full buffer (cycle 7), then again mid-stream (cycle 12).
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      cyc(!(c >= 4 && c <= 6), (c == 7 || c == 12), (c == 7) ? 8'h40 : 8'h80, 1'b1);
      case (c)
        8: begin
          chk("br_n1_vld", if_valid, 1'b0);
          chk("br_n1_rd", imem_rd, 1'b1);
          chk("br_n1_addr", imem_addr, 8'h40);
        end
        9:  chk("br_n2_vld", if_valid, 1'b0);
        10: begin
          chk("br_n3_pc", pc_out, 8'h40);
          chk("br_n3_word", {class_out, ISout}, rom[8'h40]);
        end
        11: chk("br_n4_pc", pc_out, 8'h41);
        15: chk("br2_pc", pc_out, 8'h80);
        default: ;
      endcase
    end

    // HALT at address 2, then a branch to 0x10 restarts fetch.
    rom[2] = 16'h3E00;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      cyc(1'b1, (c == 10), 8'h10, 1'b1);
      if (c >= 3 && c <= 5) chk("hlt_pc", pc_out, c - 3);
      if (c == 7 || c == 9) begin
        chk("hlt_vld", if_valid, 1'b0);
        chk("hlt_flag_d", halted, 1'b1);
        chk("hlt_rd", imem_rd, 1'b0);
      end
      if (c == 11) begin
        chk("hlt_clr", halted, 1'b0);
        chk("hlt_rd_res", imem_rd, 1'b1);
        chk("hlt_addr_res", imem_addr, 8'h10);
      end
      if (c == 13) chk("hlt_res_pc", pc_out, 8'h10);
    end
    rom[2] = 16'h7C00;

    // One-cycle reset while a word is valid.
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      cyc(1'b1, 1'b0, 8'h00, (c != 6));
      if (c == 5) chk("mr_pre_vld", if_valid, 1'b1);
      if (c == 7) begin
        chk("mr_vld", if_valid, 1'b0);
        chk("mr_addr", imem_addr, 8'h00);
      end
      if (c == 8) chk("mr_rd", imem_rd, 1'b1);
      if (c == 10) begin
        chk("mr_pc0", pc_out, 8'h00);
        chk("mr_is", ISout, 14'h1201);
      end
      if (c == 11) chk("mr_pc1", pc_out, 8'h01);
    end

    // Randomized traffic checked by the stream model.
    repeat (8) rom[$urandom_range(0, 255)] = 16'h3E00 | 16'($urandom_range(0, 511));
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0), 8'($urandom),
          ($urandom_range(0, 299) != 0));
    end
    repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
